// File: rtl/timer_555_multi.sv
// timer_555_multi: NCH independent 555-style monostable/astable timers counting a shared COUNT_EN tick.
// Define TIMER555_RETRIG_EN for a retriggerable monostable; undefined ignores triggers mid-phase.
module timer_555_multi #(
  parameter int BW  = 32,
  parameter int NCH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              COUNT_EN,
  input  logic [NCH-1:0]    MODE,
  input  logic [NCH-1:0]    CLR_N,
  input  logic [NCH-1:0]    TRG_N,
  input  logic [NCH*BW-1:0] HIGH_CNT,
  input  logic [NCH*BW-1:0] LOW_CNT,
  output logic [NCH-1:0]    OUT,
  output logic [NCH*BW-1:0] CNT_OUT
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  logic [NCH-1:0] prev_trg;
  logic [NCH-1:0] detect;
  assign detect = prev_trg & ~TRG_N;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) prev_trg <= '1;
    else prev_trg <= TRG_N;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t state, state_nxt;
    logic [BW-1:0] cnt, cnt_nxt, lim, lim_nxt, hi, lo;
    logic phase_end, retrig;
    // a programmed duration of 0 still gives a one-tick phase
    assign hi = (HIGH_CNT[i*BW +: BW] == '0) ? BW'(1) : HIGH_CNT[i*BW +: BW];
    assign lo = (LOW_CNT[i*BW +: BW] == '0) ? BW'(1) : LOW_CNT[i*BW +: BW];
    assign phase_end = (state != IDLE) && COUNT_EN && (cnt == lim - BW'(1));
`ifdef TIMER555_RETRIG_EN
    assign retrig = (state == HIGH) && !MODE[i] && detect[i];
`else
    assign retrig = 1'b0;
`endif
    always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      lim_nxt = lim;
      if (!CLR_N[i]) begin
        state_nxt = IDLE;
        cnt_nxt = '0;
      end else if ((state == IDLE && (MODE[i] || detect[i])) || retrig || (phase_end && state == LOW && MODE[i])) begin
        state_nxt = HIGH;
        cnt_nxt = '0;
        lim_nxt = hi;
      end else if (phase_end && state == HIGH && MODE[i]) begin
        state_nxt = LOW;
        cnt_nxt = '0;
        lim_nxt = lo;
      end else if (phase_end) begin
        state_nxt = IDLE;
        cnt_nxt = '0;
      end else if (state != IDLE && COUNT_EN) begin
        cnt_nxt = cnt + BW'(1);
      end
    end
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
        state <= IDLE;
        cnt <= '0;
        lim <= BW'(1);
      end else begin
        state <= state_nxt;
        cnt <= cnt_nxt;
        lim <= lim_nxt;
      end
    assign OUT[i] = state == HIGH;
    assign CNT_OUT[i*BW +: BW] = (state != IDLE) ? cnt : '0;
  end
endmodule

// File: tb/tb_timer_555_multi.sv
// tb_timer_555_multi: directed scoreboard bench for timer_555_multi (BW=8, NCH=4).
module tb_timer_555_multi;
  localparam int BW = 8;
  localparam int NCH = 4;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic COUNT_EN = 1'b1;
  logic [NCH-1:0] MODE = '0;
  logic [NCH-1:0] CLR_N = '1;
  logic [NCH-1:0] TRG_N = '1;
  logic [NCH-1:0] OUT;
  logic [NCH*BW-1:0] HIGH_CNT = '0;
  logic [NCH*BW-1:0] LOW_CNT = '0;
  logic [NCH*BW-1:0] CNT_OUT;
  int checks = 0;
  int errors = 0;
  string tag_q[$];
  int ch_q[$];
  logic out_q[$];
  logic [BW-1:0] cnt_q[$];
  timer_555_multi #(.BW(BW), .NCH(NCH)) dut (
    .CLK(CLK), .RST_N(RST_N), .COUNT_EN(COUNT_EN), .MODE(MODE), .CLR_N(CLR_N),
    .TRG_N(TRG_N), .HIGH_CNT(HIGH_CNT), .LOW_CNT(LOW_CNT), .OUT(OUT), .CNT_OUT(CNT_OUT)
  );
  always #5 CLK = ~CLK;
  task automatic push(input string t, input int c, input logic o, input logic [BW-1:0] n);
    tag_q.push_back(t);
    ch_q.push_back(c);
    out_q.push_back(o);
    cnt_q.push_back(n);
  endtask
  task automatic drain();
    while (ch_q.size() > 0) begin
      string t;
      int c;
      logic o;
      logic [BW-1:0] n;
      t = tag_q.pop_front();
      c = ch_q.pop_front();
      o = out_q.pop_front();
      n = cnt_q.pop_front();
      checks++;
      assert (OUT[c] === o) else begin
        errors++;
        $error("FAIL %s ch%0d OUT got %b exp %b", t, c, OUT[c], o);
      end
      checks++;
      assert (CNT_OUT[c*BW +: BW] === n) else begin
        errors++;
        $error("FAIL %s ch%0d CNT_OUT got %0d exp %0d", t, c, CNT_OUT[c*BW +: BW], n);
      end
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask
  initial begin
    int pw;
    @(posedge CLK);
    #1;
    for (int c = 0; c < NCH; c++) push("reset", c, 1'b0, '0);
    drain();
    HIGH_CNT[0 +: BW] = 8'd5;
    HIGH_CNT[BW +: BW] = 8'd3;
    LOW_CNT[BW +: BW] = 8'd2;
    HIGH_CNT[2*BW +: BW] = 8'd100;
    RST_N = 1'b1;
    tick();
    tick();
    TRG_N[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      push("mono", 0, k < 5, (k < 5) ? BW'(k) : '0);
      tick();
    end
    TRG_N[0] = 1'b1;
    HIGH_CNT[0 +: BW] = 8'd0;
    tick();
    TRG_N[0] = 1'b0;
    push("zero_hi", 0, 1'b1, '0);
    tick();
    push("zero_hi", 0, 1'b0, '0);
    tick();
    TRG_N[0] = 1'b1;
    MODE[1] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int j;
      j = k % 10;
      COUNT_EN = (k % 2 == 0);
      if (k == 18) MODE[1] = 1'b0;
      if (k < 20) push("astable", 1, j < 6, (j < 6) ? BW'(j / 2) : BW'((j - 6) / 2));
      else push("astable_stop", 1, 1'b0, '0);
      tick();
    end
    COUNT_EN = 1'b1;
    TRG_N[2] = 1'b0;
    push("clr_start", 2, 1'b1, '0);
    tick();
    TRG_N[2] = 1'b1;
    repeat (39) tick();
    push("clr_cnt", 2, 1'b1, 8'd40);
    tick();
    CLR_N[2] = 1'b0;
    TRG_N[2] = 1'b0;
    push("clr", 2, 1'b0, '0);
    tick();
    CLR_N[2] = 1'b1;
    push("clr_trg", 2, 1'b0, '0);
    tick();
    push("clr_trg", 2, 1'b0, '0);
    tick();
    TRG_N[2] = 1'b1;
    HIGH_CNT[0 +: BW] = 8'd5;
`ifdef TIMER555_RETRIG_EN
    pw = 8;
`else
    pw = 5;
`endif
    TRG_N[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) TRG_N[0] = 1'b1;
      if (k == 3) TRG_N[0] = 1'b0;
      if (pw == 8) push("retrig", 0, k < pw, (k < pw) ? BW'((k < 3) ? k : k - 3) : '0);
      else push("retrig", 0, k < pw, (k < pw) ? BW'(k) : '0);
      tick();
    end
    TRG_N[0] = 1'b1;
    TRG_N[3] = 1'b1;
    HIGH_CNT[0 +: BW] = 8'd2;
    HIGH_CNT[3*BW +: BW] = 8'd4;
    tick();
    TRG_N[0] = 1'b0;
    TRG_N[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push("dual0", 0, k < 2, (k < 2) ? BW'(k) : '0);
      push("dual3", 3, k < 4, (k < 4) ? BW'(k) : '0);
      tick();
    end
    TRG_N[0] = 1'b1;
    TRG_N[3] = 1'b1;
    HIGH_CNT[0 +: BW] = 8'd5;
    tick();
    TRG_N[0] = 1'b0;
    push("async_pre", 0, 1'b1, '0);
    tick();
    push("async_pre", 0, 1'b1, 8'd1);
    tick();
    #3;
    RST_N = 1'b0;
    #1;
    push("async_rst", 0, 1'b0, '0);
    drain();
    push("in_rst", 0, 1'b0, '0);
    tick();
    TRG_N[0] = 1'b1;
    #2;
    RST_N = 1'b1;
    push("post_rst", 0, 1'b0, '0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_555_multi.md
# timer_555_multi

Multi-channel 555 timer emulation for the discrete-logic arcade cores. Each of NCH independent channels runs as either a monostable one-shot or a free-running astable oscillator, and counts a shared clock-enable tick. Every channel has its own programmable high and low durations, its own trigger, and its own 555-style clear pin. The block replaces per-instance single-channel one-shots wherever a board uses several 555s clocked from the same timebase.

## Interface

Parameters:
- BW, default 32: counter and duration width per channel.
- NCH, default 4: number of timer channels, 1..32.

Ports:
- CLK  in  1: system clock.
- RST_N  in  1: asynchronous active-low reset.
- COUNT_EN  in  1: shared count tick; a counter advances only on cycles with COUNT_EN=1.
- MODE  in  NCH: per channel, 0 = monostable, 1 = astable.
- CLR_N  in  NCH: per-channel 555 reset pin, active-low, synchronous; forces the channel to IDLE.
- TRG_N  in  NCH: per-channel trigger; acts on its falling edge.
- HIGH_CNT  in  NCH*BW: ticks in the HIGH phase; channel i uses bits [i*BW +: BW].
- LOW_CNT  in  NCH*BW: ticks in the LOW phase (astable only); same packing.
- OUT  out  NCH: per-channel output, 1 in the HIGH phase.
- CNT_OUT  out  NCH*BW: per-channel current counter value; 0 in IDLE.

## Operation

- Per-channel state machine with three states: IDLE, HIGH, LOW. The state encoding is internal.
- **Edge detect.** `prev_trg[i]` is registered. `detect[i] = prev_trg[i] & ~TRG_N[i]`.
- **Phase start.** On entry to HIGH or LOW:
  - the counter clears to 0;
  - the duration for that phase (HIGH_CNT or LOW_CNT) is latched into a per-channel limit register.
  - A latched value of 0 is treated as 1.
  - Input changes during a phase do not affect the running phase.
- **Counting.** In HIGH or LOW with COUNT_EN=1:
  - if counter == limit-1, the phase ends;
  - otherwise the counter increments.
  - With COUNT_EN=0 the counter holds.
- **Transitions** (CLR_N[i]=0 overrides all of these):
  - IDLE → HIGH when MODE=0 and detect=1.
  - IDLE → HIGH when MODE=1. Trigger is ignored in astable mode.
  - End of HIGH → LOW if MODE=1, else → IDLE.
  - End of LOW → HIGH if MODE=1, else → IDLE.
  - MODE is sampled at phase ends only.
- **Clear.** CLR_N[i]=0 sends the channel to IDLE on the next edge and clears its counter. A trigger edge coincident with CLR_N=0 is discarded.
- **Outputs.** OUT[i] = (state==HIGH). CNT_OUT[i] = counter in HIGH or LOW, else 0. Both decode combinationally from registered state, with no extra register stage.
- **Channel isolation.** Channels share no state other than COUNT_EN.

## Timing

- **Reset values.** On RST_N low:
  - every state = IDLE, every counter = 0, every limit = 1;
  - `prev_trg` = all ones, so a trigger held low through reset does not fire;
  - OUT = 0 and CNT_OUT = 0.
- **Trigger latency.** If TRG_N[i] is first sampled low at edge n (it was high at n-1), OUT[i] is 1 from edge n.
- **Pulse width.** With COUNT_EN held at 1, a monostable pulse lasts exactly HIGH_CNT cycles. More generally, it lasts until the HIGH_CNT-th enabled tick, inclusive.
- **Back-to-back trigger.** A falling edge in the same cycle that HIGH ends to IDLE is not accepted; the channel must be in IDLE when the edge is detected.
- **Astable period.** HIGH_CNT + LOW_CNT enabled ticks.
  - With COUNT_EN=1 continuously, OUT is periodic with no idle gap cycles.
  - Leaving CLR_N=0 with MODE=1 gives one IDLE cycle, then HIGH.
- **Counter wrap.** Wrap is impossible, because the limit is at most 2^BW-1.

## Configuration

- **Macro:** TIMER555_RETRIG_EN.
- **Defined (retriggerable monostable):** in HIGH with MODE=0, detect=1 and CLR_N=1 restarts the phase. The counter clears and HIGH_CNT is relatched, so the pulse is extended. If the retrigger coincides with the phase-end tick, the retrigger wins and the channel stays in HIGH.
- **Undefined:** a trigger edge during HIGH or LOW is ignored, as in a real 555 one-shot.

## Test plan

- **Monostable pulse.** NCH=4, BW=8. Ch0 MODE=0, HIGH_CNT=5, COUNT_EN=1. TRG_N[0] falls at edge 10 → OUT[0]=1 for edges 10..14. CNT_OUT[0] steps 0,1,2,3,4 then reads 0 with OUT[0]=0.
- **Astable with gated enable.** Ch1 MODE=1, HIGH_CNT=3, LOW_CNT=2, COUNT_EN toggled every other cycle → OUT[1] high for 6 clocks and low for 4, repeating. Set MODE=0 mid-LOW → the current LOW completes, then IDLE stays.
- **Clear mid-pulse.** Trigger ch2 with HIGH_CNT=100. Pull CLR_N[2] low at count 40 → next edge OUT[2]=0 and CNT_OUT[2]=0. A simultaneous trigger is ignored.
- **Reset behaviour.** Hold TRG_N low through RST_N deassertion → no pulse. Assert RST_N asynchronously mid-pulse → OUT=0 immediately, without waiting for a clock edge.
- **Retrigger.** Retrigger at count 3 with HIGH_CNT=5 → with TIMER555_RETRIG_EN: pulse of 8 cycles total. Without: 5 cycles.
- **Edge cases.** HIGH_CNT=0 → 1-cycle pulse. Triggering ch0 and ch3 simultaneously with different counts → independent pulse widths.
